fc_layer_ctrl: RTL and testbench

FC_LAYER_CTRL -- requirements
Module: fc_layer_ctrl

---
 rtl/fc_layer_ctrl_if.sv | 32 +++
 rtl/fc_layer_ctrl.sv | 149 ++++++++++++++
 tb/tb_fc_layer_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_layer_ctrl_if.sv
// Handshake bundle for fc_layer_ctrl.
// Carries the activation input stream, the flush control and the result output stream.
//   in_valid/in_ready/in_data    : activation stream into the block
//   flush                        : synchronous frame abort
//   out_valid/out_ready          : result stream handshake
//   out_data/out_idx             : result value and its neuron index
// Modports: master = stream source and result sink (testbench or upstream logic).
//           slave  = the controller.
interface fc_layer_ctrl_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ZW    = 23,
    parameter int unsigned IW    = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ZW-1:0]    out_data;
    logic [IW-1:0]    out_idx;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_idx
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_idx
    );
endinterface

// File: rtl/fc_layer_ctrl.sv
// Fully-connected layer controller.
// Buffers IN activations into x_bus, waits for the external combinational layer to settle,
// captures all OUT neuron results from z_bus in one cycle, then streams them out in index
// order.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : fc_layer_ctrl_if.slave (activation stream, flush, result stream)
//   x_bus       : activation buffer to the datapath, word k at [k*WIDTH +: WIDTH]
//   z_bus       : neuron outputs from the datapath, neuron j at [j*ZW +: ZW]
//   busy        : frame in progress
//   frame_done  : one-cycle pulse after the last result handshake
//   argmax_idx  : index of the largest captured result
// Build option: define FC_LAYER_CTRL_ARGMAX_EN to build the argmax comparator; otherwise
// argmax_idx is tied to 0.
module fc_layer_ctrl #(
    parameter int unsigned  WIDTH  = 8,
    parameter int unsigned  IN     = 128,
    parameter int unsigned  OUT    = 10,
    parameter int unsigned  ZW     = 23,
    parameter int unsigned  SETTLE = 2,
    localparam int unsigned IW     = (OUT > 1) ? $clog2(OUT) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fc_layer_ctrl_if.slave        bus,
    output logic [IN*WIDTH-1:0]   x_bus,
    input  logic [OUT*ZW-1:0]     z_bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic [IW-1:0]         argmax_idx
);
    localparam int unsigned LW = (IN > 1) ? $clog2(IN) : 1;

    localparam logic [1:0] S_LOAD    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    logic [1:0]        state;
    logic [LW-1:0]     ld_cnt;
    logic [3:0]        st_cnt;
    logic [IW-1:0]     out_idx;
    logic [OUT*ZW-1:0] res;
    logic              done_q;
    logic              in_acc;
    logic              out_hs;

    assign bus.in_ready  = (state == S_LOAD);
    assign bus.out_valid = (state == S_DRAIN);
    assign bus.out_data  = res[out_idx*ZW +: ZW];
    assign bus.out_idx   = out_idx;
    assign in_acc        = bus.in_valid & bus.in_ready;
    assign out_hs        = bus.out_valid & bus.out_ready;
    assign busy          = (state != S_LOAD) || (ld_cnt != '0);
    assign frame_done    = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_LOAD;
            ld_cnt  <= '0;
            st_cnt  <= '0;
            out_idx <= '0;
            x_bus   <= '0;
            res     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // flush wins over any handshake in the same cycle; buffer contents are kept
            if (bus.flush) begin
                state   <= S_LOAD;
                ld_cnt  <= '0;
                st_cnt  <= '0;
                out_idx <= '0;
            end else begin
                case (state)
                    S_LOAD: begin
                        if (in_acc) begin
                            x_bus[ld_cnt*WIDTH +: WIDTH] <= bus.in_data;
                            if (ld_cnt == LW'(IN - 1)) begin
                                ld_cnt <= '0;
                                // Counting down from SETTLE gives SETTLE+1 wait cycles, so
                                // out_valid rises SETTLE+2 edges after the final accept.
                                st_cnt <= 4'(SETTLE);
                                state  <= S_SETTLE;
                            end else begin
                                ld_cnt <= ld_cnt + 1'b1;
                            end
                        end
                    end
                    S_SETTLE: begin
                        if (st_cnt == '0) begin
                            state <= S_CAPTURE;
                        end else begin
                            st_cnt <= st_cnt - 1'b1;
                        end
                    end
                    S_CAPTURE: begin
                        res     <= z_bus;
                        out_idx <= '0;
                        state   <= S_DRAIN;
                    end
                    S_DRAIN: begin
                        if (out_hs) begin
                            if (out_idx == IW'(OUT - 1)) begin
                                out_idx <= '0;
                                done_q  <= 1'b1;
                                state   <= S_LOAD;
                            end else begin
                                out_idx <= out_idx + 1'b1;
                            end
                        end
                    end
                    default: state <= S_LOAD;
                endcase
            end
        end
    end

`ifdef FC_LAYER_CTRL_ARGMAX_EN
    logic [ZW-1:0] best_val;
    logic [IW-1:0] best_idx;
    logic [IW-1:0] argmax_q;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        best_val = z_bus[0 +: ZW];
        best_idx = '0;
        for (int j = 1; j < int'(OUT); j++) begin
            if (z_bus[j*ZW +: ZW] > best_val) begin
                best_val = z_bus[j*ZW +: ZW];
                best_idx = IW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            argmax_q <= '0;
        end else if (state == S_CAPTURE && !bus.flush) begin
            argmax_q <= best_idx;
        end
    end

    assign argmax_idx = argmax_q;
`else
    assign argmax_idx = '0;
`endif

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Self-checking bench for fc_layer_ctrl: randomized frames checked cycle by cycle against
// a frame-level reference model (phase, load count, settle countdown, drain index).
module tb_fc_layer_ctrl;
    localparam int WIDTH  = 8;
    localparam int IN     = 128;
    localparam int OUT    = 10;
    localparam int ZW     = 23;
    localparam int SETTLE = 2;
    localparam int IW     = $clog2(OUT);
`ifdef FC_LAYER_CTRL_ARGMAX_EN
    localparam bit AM = 1'b1;
`else
    localparam bit AM = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [IN*WIDTH-1:0] x_bus;
    logic [OUT*ZW-1:0]   z_bus;
    logic                busy;
    logic                frame_done;
    logic [IW-1:0]       argmax_idx;

    fc_layer_ctrl_if #(.WIDTH(WIDTH), .ZW(ZW), .IW(IW)) bus ();

    fc_layer_ctrl #(
        .WIDTH (WIDTH),
        .IN    (IN),
        .OUT   (OUT),
        .ZW    (ZW),
        .SETTLE(SETTLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .x_bus     (x_bus),
        .z_bus     (z_bus),
        .busy      (busy),
        .frame_done(frame_done),
        .argmax_idx(argmax_idx)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [WIDTH-1:0] mbuf[IN];
    logic [ZW-1:0]    zval[OUT];
    logic [ZW-1:0]    mres[OUT];
    int               mld;
    int               phase;     // 0 loading, 1 waiting for results, 2 draining
    int               wait_cnt;
    int               midx;
    int               m_arg;
    int               total = 0;
    int               bad = 0;

    always_comb begin
        z_bus = '0;
        for (int j = 0; j < OUT; j++) z_bus[j*ZW +: ZW] = zval[j];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_argmax();
        int best = 0;
        for (int j = 1; j < OUT; j++) if (zval[j] > zval[best]) best = j;
        return best;
    endfunction

    task automatic model_reset();
        mld = 0; phase = 0; wait_cnt = 0; midx = 0; m_arg = 0;
        for (int k = 0; k < IN; k++) mbuf[k] = '0;
    endtask

    task automatic check_xbus();
        for (int k = 0; k < IN; k++) check("x_bus", 64'(x_bus[k*WIDTH +: WIDTH]), 64'(mbuf[k]));
    endtask

    task automatic rand_z();
        for (int j = 0; j < OUT; j++) zval[j] = ZW'($urandom);
        if ($urandom_range(1) == 0) zval[$urandom_range(OUT-1)] = zval[$urandom_range(OUT-1)];
    endtask

    // One clock: sample inputs before the edge, advance the model, compare after the edge.
    task automatic tick();
        bit acc, hs, fl, dn;
        logic [WIDTH-1:0] id;
        acc = bus.in_valid && (phase == 0);
        hs  = bus.out_ready && (phase == 2);
        fl  = bus.flush;
        id  = bus.in_data;
        dn  = 1'b0;
        @(posedge clk);
        #1;
        if (fl) begin
            mld = 0; phase = 0; midx = 0;
        end else if (phase == 0) begin
            if (acc) begin
                mbuf[mld] = id;
                mld++;
                if (mld == IN) begin
                    mld = 0; phase = 1; wait_cnt = SETTLE + 2;
                    for (int j = 0; j < OUT; j++) mres[j] = zval[j];
                    m_arg = ref_argmax();
                end
            end
        end else if (phase == 1) begin
            wait_cnt--;
            if (wait_cnt == 0) begin phase = 2; midx = 0; end
        end else if (hs) begin
            if (midx == OUT - 1) begin phase = 0; midx = 0; dn = 1'b1; end
            else midx++;
        end
        check("in_ready", 64'(bus.in_ready), 64'(phase == 0));
        check("out_valid", 64'(bus.out_valid), 64'(phase == 2));
        check("busy", 64'(busy), 64'(phase != 0 || mld != 0));
        check("frame_done", 64'(frame_done), 64'(dn));
        if (phase == 2) begin
            check("out_idx", 64'(bus.out_idx), 64'(midx));
            check("out_data", 64'(bus.out_data), 64'(mres[midx]));
        end
        if (dn) check("argmax", 64'(argmax_idx), AM ? 64'(m_arg) : 64'd0);
    endtask

    task automatic load_frame(input int n, input int gap, input bit seq);
        int cnt = 0;
        int guard = 0;
        while (cnt < n && guard < 20 * n + 50) begin
            bus.in_valid = ($urandom_range(99) >= gap);
            bus.in_data  = seq ? WIDTH'(cnt + 1) : WIDTH'($urandom);
            if (bus.in_valid && phase == 0) cnt++;
            tick();
            guard++;
        end
        if (cnt < n) check("load_timeout", 64'(cnt), 64'(n));
    endtask

    task automatic drain(input int stall, input int hold_at, input int stop_at, output int cyc);
        int guard = 0;
        int held = 0;
        cyc = 0;
        while (phase != 2 && guard < 50) begin
            bus.out_ready = 1'b0;
            tick();
            guard++;
        end
        if (phase != 2) check("out_valid_timeout", 64'(phase), 64'd2);
        guard = 0;
        while (phase == 2 && guard < 1000) begin
            if (stop_at >= 0 && midx == stop_at) break;
            if (hold_at >= 0 && midx == hold_at && held < 5) begin
                bus.out_ready = 1'b0;
                held++;
            end else begin
                bus.out_ready = ($urandom_range(99) >= stall);
            end
            tick();
            guard++;
            cyc++;
        end
        if (phase == 2 && stop_at < 0) check("drain_timeout", 64'(phase), 64'd0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int cyc;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        for (int j = 0; j < OUT; j++) zval[j] = '0;
        model_reset();

        // reset state
        #12;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_argmax", 64'(argmax_idx), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check_xbus();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // sequential words 1..IN, in_valid held high, z field j = 100*j
        for (int j = 0; j < OUT; j++) zval[j] = ZW'(100 * j);
        load_frame(IN, 0, 1'b1);
        check("in_ready_after_last", 64'(bus.in_ready), 64'd0);
        n = 0;
        while (!bus.out_valid && n < 20) begin tick(); n++; end
        check("latency", 64'(n), 64'(SETTLE + 2));
        check("x_word5", 64'(x_bus[5*WIDTH +: WIDTH]), 64'd6);
        check_xbus();
        bus.in_valid = 1'b0;
        drain(0, -1, -1, cyc);
        check("drain_cycles", 64'(cyc), 64'(OUT));
        tick();

        // random frame with gaps, output held for 5 cycles at index 3
        rand_z();
        load_frame(IN, 30, 1'b0);
        bus.in_valid = 1'b0;
        drain(0, 3, -1, cyc);
        check("hold_cycles", 64'(cyc), 64'(OUT + 5));

        // flush after 60 words with a simultaneous input handshake
        rand_z();
        load_frame(60, 20, 1'b0);
        bus.in_valid = 1'b1; bus.in_data = 8'hA5; bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check_xbus();
        load_frame(IN, 10, 1'b0);
        bus.in_valid = 1'b0;
        drain(40, -1, -1, cyc);

        // flush during drain with a simultaneous output handshake
        rand_z();
        load_frame(IN, 0, 1'b0);
        bus.in_valid = 1'b0;
        drain(0, -1, 2, cyc);
        bus.out_ready = 1'b1; bus.flush = 1'b1;
        tick();
        bus.out_ready = 1'b0; bus.flush = 1'b0;
        tick();

        // back-to-back frames: next load starts in the frame_done cycle
        rand_z();
        load_frame(IN, 15, 1'b0);
        bus.in_valid = 1'b0;
        drain(20, -1, -1, cyc);
        check("b2b_ready", 64'(bus.in_ready), 64'd1);
        rand_z();
        load_frame(IN, 0, 1'b0);
        bus.in_valid = 1'b0;
        drain(0, -1, -1, cyc);

        // tie on the maximum: lowest index wins
        for (int j = 0; j < OUT; j++) zval[j] = ZW'(10);
        zval[2] = ZW'(500); zval[7] = ZW'(500);
        load_frame(IN, 5, 1'b0);
        bus.in_valid = 1'b0;
        drain(10, -1, -1, cyc);

        // asynchronous reset mid-drain at index 4
        rand_z();
        load_frame(IN, 0, 1'b0);
        bus.in_valid = 1'b0;
        drain(0, -1, 4, cyc);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_in_ready", 64'(bus.in_ready), 64'd1);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_out_idx", 64'(bus.out_idx), 64'd0);
        check("arst_argmax", 64'(argmax_idx), 64'd0);
        model_reset();
        check_xbus();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rand_z();
        load_frame(IN, 25, 1'b0);
        bus.in_valid = 1'b0;
        check_xbus();
        drain(30, -1, -1, cyc);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
